sid_master: RTL and testbench
=============================

Name: sid_master

Overview:
- Local bus initiator that runs single-byte read/write cycles against a slave window on the card's internal slave bus (the SID/DIP shadow register at 0x8C0000), using the FCS_n/READ/ADDR[23:17]/D[31:24] strobe protocol with a DTACK handshake.
- After reset it fetches the configuration byte once and latches it, e.g. for termination and ID bits.
- Afterwards it serves on-demand requests from local logic.
- Includes a timeout so that a missing responder cannot hang the card.

Parameters:
- SID_ADDR, 7'h46, A[23:17] value driven for the auto-fetch cycle.
- SETUP_CYCLES, 1, clocks address/READ/data are stable before FCS_n falls (1..15).
- TIMEOUT, 64, max clocks waited in any DTACK-wait state (2..255).
- AUTO_FETCH, 1, 1 = perform one read of SID_ADDR after reset.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req  in  1  one-cycle request pulse; sampled only when busy=0.
- req_write  in  1  1 = write, 0 = read; sampled with req.
- req_addr  in  7  A[23:17] for the request.
- req_wdata  in  8  write byte.
- busy  out  1  cycle in progress (includes auto-fetch).
- done  out  1  one-cycle pulse at end of any cycle.
- err  out  1  one-cycle pulse coincident with done when the cycle timed out.
- rdata  out  8  last read byte; FF on timeout.
- cfg_byte  out  8  byte captured by the auto-fetch.
- cfg_valid  out  1  high once the auto-fetch completed without error; sticky until reset.
- ADDR  out  7  bus address A[23:17].
- READ  out  1  bus direction; 1 = read.
- FCS_n  out  1  bus strobe, active low.
- DOUT  out  8  write data on D[31:24].
- DOE  out  1  data output enable; high only during write cycles.
- DIN  in  8  read data D[31:24].
- DTACK  in  1  responder acknowledge, active high, synchronous to CLK.

Behaviour:
- Reset values:
  - busy = 0, done = 0, err = 0.
  - rdata = FF, cfg_byte = FF, cfg_valid = 0.
  - ADDR = 0, READ = 1, FCS_n = 1, DOUT = 0, DOE = 0.
  - State IDLE; fetch_pending = AUTO_FETCH.
- States: IDLE, SETUP, STROBE, RELEASE, FINISH.
- IDLE:
  - If fetch_pending: load ADDR = SID_ADDR, READ = 1, and go to SETUP. This takes priority over req in the same cycle; that req is dropped.
  - Else on req: load ADDR = req_addr, READ = !req_write, DOUT = req_wdata, DOE = req_write, set busy, and go to SETUP.
- SETUP:
  - Counts SETUP_CYCLES clocks.
  - Then FCS_n goes to 0, the timer clears, and the state moves to STROBE.
- STROBE: waits for DTACK = 1.
  - On DTACK: for reads, capture rdata <= DIN in that cycle. Drive FCS_n = 1 and go to RELEASE.
  - On timer reaching TIMEOUT: FCS_n = 1, rdata = FF (read) or unchanged (write), set the timeout flag, and go to RELEASE.
- RELEASE: waits for DTACK = 0.
  - The responder holds DTACK until it sees FCS_n high.
  - The timer restarts on entry. If DTACK is still high after TIMEOUT clocks, set the timeout flag and go to FINISH anyway.
- FINISH (one clock):
  - Pulse done; pulse err if the timeout flag is set.
  - Set DOE = 0, READ = 1, busy = 0.
  - If this was the auto-fetch: cfg_byte <= rdata; cfg_valid <= !timeout; fetch_pending <= 0. The auto-fetch is attempted once only; no retry.
  - Return to IDLE.
- Latency, from the req cycle with SETUP_CYCLES = 1 and the responder giving DTACK 1 clock after strobe:
  - FCS_n low at +2.
  - done at +6.
  - A new req is accepted the cycle after done.
- busy is high from the clock after the req sample through FINISH. req while busy = 1 is ignored, not queued.
- The auto-fetch holds busy high from the first clock after reset release.
- DTACK already high on entry to STROBE: accepted immediately (one-clock strobe).
- The timer is 8 bits and saturates; it does not wrap.
- RESET asserted mid-cycle: all outputs go to reset values immediately (FCS_n = 1, DOE = 0). The in-flight cycle is abandoned without done/err, and the auto-fetch re-arms.
- DOE never changes while FCS_n = 0. ADDR, READ and DOUT are held constant from SETUP entry until FINISH.

Test Plan:
- Reset release with responder returning DIN = 8'h5A, DTACK 1 clock after FCS_n low -> ADDR = 7'h46, READ = 1, one FCS_n pulse; cfg_byte = 5A, cfg_valid = 1, done pulses once, err = 0.
- Write req_addr = 46, req_wdata = 8'h01 -> READ = 0, DOE = 1 with DOUT = 01 held through the strobe; done at +6; a subsequent read returns 01 in rdata.
- Responder absent (DTACK stuck 0), TIMEOUT = 64 -> FCS_n low exactly 64 clocks, then done + err; rdata = FF; on auto-fetch cfg_valid stays 0 and no retry occurs.
- DTACK stuck 1 after release -> RELEASE times out after 64 clocks; err pulses, busy drops, and the next req is accepted.
- req pulsed while busy, and req in the first clock after reset -> both ignored; exactly one bus cycle (the auto-fetch) observed.
- RESET asserted while FCS_n = 0 in a write -> FCS_n = 1 and DOE = 0 asynchronously, no done; after release a fresh auto-fetch runs.

Source files
------------

// File: rtl/sid_master.sv
`default_nettype none
// ============================================================================
// Module      : sid_master
// Description : Local bus initiator for single-byte FCS_n/DTACK cycles; fetches
//               the SID/DIP configuration byte once after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sid_master #(
    parameter logic [6:0] SID_ADDR     = 7'h46,
    parameter int         SETUP_CYCLES = 1,
    parameter int         TIMEOUT      = 64,
    parameter bit         AUTO_FETCH   = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic [7:0] cfg_byte,
    output logic       cfg_valid,
    output logic [6:0] ADDR,
    output logic       READ,
    output logic       FCS_n,
    output logic [7:0] DOUT,
    output logic       DOE,
    input  logic [7:0] DIN,
    input  logic       DTACK
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_strobe  = 3'd2;
    localparam logic [2:0] c_st_release = 3'd3;
    localparam logic [2:0] c_st_finish  = 3'd4;

    localparam logic [3:0] c_setup_last   = 4'(SETUP_CYCLES - 1);
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    logic [2:0] r_state,         w_state_nxt;
    logic [3:0] r_setup_cnt,     w_setup_cnt_nxt;
    logic [7:0] r_timer,         w_timer_nxt;
    logic       r_timeout,       w_timeout_nxt;
    logic       r_fetch_pending, w_fetch_pending_nxt;
    logic [6:0] r_addr,          w_addr_nxt;
    logic       r_read,          w_read_nxt;
    logic       r_fcs_n,         w_fcs_n_nxt;
    logic [7:0] r_dout,          w_dout_nxt;
    logic       r_doe,           w_doe_nxt;
    logic [7:0] r_rdata,         w_rdata_nxt;
    logic [7:0] r_cfg_byte,      w_cfg_byte_nxt;
    logic       r_cfg_valid,     w_cfg_valid_nxt;
    logic [7:0] w_timer_inc;

    // Saturating timer: a stuck responder can never wrap it back into range.
    assign w_timer_inc = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state         <= c_st_idle;
            r_setup_cnt     <= 4'd0;
            r_timer         <= 8'd0;
            r_timeout       <= 1'b0;
            r_fetch_pending <= AUTO_FETCH;
            r_addr          <= 7'd0;
            r_read          <= 1'b1;
            r_fcs_n         <= 1'b1;
            r_dout          <= 8'd0;
            r_doe           <= 1'b0;
            r_rdata         <= 8'hFF;
            r_cfg_byte      <= 8'hFF;
            r_cfg_valid     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_setup_cnt     <= w_setup_cnt_nxt;
            r_timer         <= w_timer_nxt;
            r_timeout       <= w_timeout_nxt;
            r_fetch_pending <= w_fetch_pending_nxt;
            r_addr          <= w_addr_nxt;
            r_read          <= w_read_nxt;
            r_fcs_n         <= w_fcs_n_nxt;
            r_dout          <= w_dout_nxt;
            r_doe           <= w_doe_nxt;
            r_rdata         <= w_rdata_nxt;
            r_cfg_byte      <= w_cfg_byte_nxt;
            r_cfg_valid     <= w_cfg_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_setup_cnt_nxt     = r_setup_cnt;
        w_timer_nxt         = r_timer;
        w_timeout_nxt       = r_timeout;
        w_fetch_pending_nxt = r_fetch_pending;
        w_addr_nxt          = r_addr;
        w_read_nxt          = r_read;
        w_fcs_n_nxt         = r_fcs_n;
        w_dout_nxt          = r_dout;
        w_doe_nxt           = r_doe;
        w_rdata_nxt         = r_rdata;
        w_cfg_byte_nxt      = r_cfg_byte;
        w_cfg_valid_nxt     = r_cfg_valid;

        case (r_state)
            c_st_idle: begin
                w_timeout_nxt   = 1'b0;
                w_setup_cnt_nxt = 4'd0;
                // The pending auto-fetch wins; a coincident req is dropped.
                if (r_fetch_pending) begin
                    w_addr_nxt  = SID_ADDR;
                    w_read_nxt  = 1'b1;
                    w_state_nxt = c_st_setup;
                end else if (req) begin
                    w_addr_nxt  = req_addr;
                    w_read_nxt  = !req_write;
                    w_dout_nxt  = req_wdata;
                    w_doe_nxt   = req_write;
                    w_state_nxt = c_st_setup;
                end
            end
            c_st_setup: begin
                if (r_setup_cnt == c_setup_last) begin
                    w_fcs_n_nxt = 1'b0;
                    w_timer_nxt = 8'd0;
                    w_state_nxt = c_st_strobe;
                end else begin
                    w_setup_cnt_nxt = r_setup_cnt + 4'd1;
                end
            end
            c_st_strobe: begin
                if (DTACK) begin
                    if (r_read) w_rdata_nxt = DIN;
                    w_fcs_n_nxt = 1'b1;
                    w_timer_nxt = 8'd0;
                    w_state_nxt = c_st_release;
                end else if (r_timer == c_timeout_last) begin
                    if (r_read) w_rdata_nxt = 8'hFF;
                    w_fcs_n_nxt   = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_timer_nxt   = 8'd0;
                    w_state_nxt   = c_st_release;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            c_st_release: begin
                if (!DTACK) begin
                    w_state_nxt = c_st_finish;
                end else if (r_timer == c_timeout_last) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = c_st_finish;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            c_st_finish: begin
                w_doe_nxt  = 1'b0;
                w_read_nxt = 1'b1;
                // Only the auto-fetch runs while fetch_pending is set; one attempt, no retry.
                if (r_fetch_pending) begin
                    w_cfg_byte_nxt      = r_rdata;
                    w_cfg_valid_nxt     = !r_timeout;
                    w_fetch_pending_nxt = 1'b0;
                end
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign busy      = (r_state != c_st_idle);
    assign done      = (r_state == c_st_finish);
    assign err       = done & r_timeout;
    assign rdata     = r_rdata;
    assign cfg_byte  = r_cfg_byte;
    assign cfg_valid = r_cfg_valid;
    assign ADDR      = r_addr;
    assign READ      = r_read;
    assign FCS_n     = r_fcs_n;
    assign DOUT      = r_dout;
    assign DOE       = r_doe;

endmodule
`default_nettype wire

// File: tb/tb_sid_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sid_master
// Description : Self-checking bench for sid_master with a memory-backed responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_master;

    localparam logic [6:0] c_sid_addr = 7'h46;
    localparam int         c_setup    = 1;
    localparam int         c_timeout  = 64;
    localparam int         c_m_normal = 0;
    localparam int         c_m_absent = 1;
    localparam int         c_m_stuck  = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       req = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = 7'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       busy, done, err, cfg_valid, READ, FCS_n, DOE;
    logic [7:0] rdata, cfg_byte, DOUT;
    logic [6:0] ADDR;
    logic [7:0] DIN;
    logic       DTACK;

    int checks = 0;
    int errors = 0;
    int fcs_falls = 0;
    int resp_mode = 0;
    int resp_delay = 0;
    int low_cnt;
    logic [7:0] exp_rdata = 8'hFF;

    logic [7:0] slave_mem [128] = '{default: 8'h00};
    logic       slave_wr  [128] = '{default: 1'b0};
    logic [7:0] model_mem [128] = '{default: 8'h00};
    logic       model_wr  [128] = '{default: 1'b0};

    sid_master #(
        .SID_ADDR    (c_sid_addr),
        .SETUP_CYCLES(c_setup),
        .TIMEOUT     (c_timeout),
        .AUTO_FETCH  (1'b1)
    ) u_dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .req      (req),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .cfg_byte (cfg_byte),
        .cfg_valid(cfg_valid),
        .ADDR     (ADDR),
        .READ     (READ),
        .FCS_n    (FCS_n),
        .DOUT     (DOUT),
        .DOE      (DOE),
        .DIN      (DIN),
        .DTACK    (DTACK)
    );

    always #5 CLK = ~CLK;

    always @(negedge FCS_n) fcs_falls = fcs_falls + 1;

    // Power-up contents of the slave window; address 0x46 holds 0x5A.
    function automatic logic [7:0] init_byte(input logic [6:0] a);
        return 8'h5A ^ {a, 1'b0} ^ 8'h8C;
    endfunction

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        return model_wr[a] ? model_mem[a] : init_byte(a);
    endfunction

    // Responder: acks resp_delay clocks after it first sees FCS_n low, holds
    // DTACK until it sees FCS_n high (forever in stuck mode), never acks when absent.
    always @(posedge CLK) begin
        if (FCS_n) begin
            low_cnt <= 0;
            if (resp_mode != c_m_stuck) DTACK <= 1'b0;
        end else begin
            low_cnt <= low_cnt + 1;
            if (resp_mode != c_m_absent && !DTACK && low_cnt >= resp_delay) begin
                DTACK <= 1'b1;
                if (READ) begin
                    DIN <= slave_wr[ADDR] ? slave_mem[ADDR] : init_byte(ADDR);
                end else begin
                    slave_mem[ADDR] <= DOUT;
                    slave_wr[ADDR]  <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected cycle timing, counted in clocks from the edge that samples the request.
    function automatic int exp_lat(input int mode, input int d);
        if (mode == c_m_absent) return c_setup + c_timeout + 2;
        if (mode == c_m_stuck) return c_setup + c_timeout + 3;
        return c_setup + 5 + d;
    endfunction

    function automatic int exp_low(input int mode, input int d);
        if (mode == c_m_absent) return c_timeout;
        return 2 + d;
    endfunction

    task automatic observe(input logic [6:0] ea, input bit er, input bit ew, input logic [7:0] ed,
                           input bit poke, output int lat, output int low, output int first_low,
                           output bit e, output bit stable, output bit idle);
        lat = -1; low = 0; first_low = 0; e = 1'b0; stable = 1'b1; idle = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge CLK);
            #1;
            if (n == 1) req = 1'b0;
            if (poke && n == 3) begin
                req = 1'b1; req_write = ~ew; req_addr = ~ea; req_wdata = ~ed;
            end
            if (poke && n == 4) req = 1'b0;
            if (!busy) stable = 1'b0;
            if (ADDR != ea || READ != er || DOE != ew) stable = 1'b0;
            if (ew && DOUT != ed) stable = 1'b0;
            if (err && !done) stable = 1'b0;
            if (!FCS_n) begin
                low++;
                if (first_low == 0) first_low = n;
            end
            if (done) begin
                lat = n;
                e = err;
                break;
            end
        end
        @(posedge CLK);
        #1;
        idle = !busy && !done && FCS_n && !DOE && READ;
    endtask

    task automatic run_txn(input bit wr, input logic [6:0] a, input logic [7:0] wd,
                           input int mode, input int d, input bit poke);
        int lat, low, first_low, f0;
        bit e, stable, idle;
        @(negedge CLK);
        resp_mode = mode; resp_delay = d;
        req = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        f0 = fcs_falls;
        observe(a, !wr, wr, wd, poke, lat, low, first_low, e, stable, idle);
        if (wr && mode != c_m_absent) begin
            model_mem[a] = wd;
            model_wr[a]  = 1'b1;
        end
        if (!wr) exp_rdata = (mode == c_m_absent) ? 8'hFF : model_rd(a);
        check("txn_latency", lat, exp_lat(mode, d));
        check("txn_fcs_low", low, exp_low(mode, d));
        check("txn_fcs_first", first_low, c_setup + 1);
        check("txn_err", 32'(e), 32'(mode != c_m_normal));
        check("txn_bus_stable", 32'(stable), 32'd1);
        check("txn_idle_after", 32'(idle), 32'd1);
        check("txn_rdata", 32'(rdata), 32'(exp_rdata));
        check("txn_one_strobe", fcs_falls - f0, 1);
    endtask

    task automatic do_fetch(input int mode, input bit req_first);
        int lat, low, first_low, f0;
        bit e, stable, idle;
        @(negedge CLK);
        RESET = 1'b1; resp_mode = mode; resp_delay = 0; req = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_status", 32'({busy, done, err, cfg_valid, rdata, cfg_byte}), 32'({4'b0000, 8'hFF, 8'hFF}));
        check("rst_bus", 32'({ADDR, READ, FCS_n, DOUT, DOE}), 32'({7'h00, 1'b1, 1'b1, 8'h00, 1'b0}));
        exp_rdata = 8'hFF;
        RESET = 1'b0;
        if (req_first) begin
            req = 1'b1; req_write = 1'b1; req_addr = 7'($urandom); req_wdata = 8'($urandom);
        end
        f0 = fcs_falls;
        observe(c_sid_addr, 1'b1, 1'b0, 8'h00, 1'b1, lat, low, first_low, e, stable, idle);
        if (mode == c_m_normal) exp_rdata = model_rd(c_sid_addr);
        check("fetch_latency", lat, exp_lat(mode, 0));
        check("fetch_fcs_low", low, exp_low(mode, 0));
        check("fetch_fcs_first", first_low, c_setup + 1);
        check("fetch_err", 32'(e), 32'(mode != c_m_normal));
        check("fetch_bus_stable", 32'(stable), 32'd1);
        check("fetch_idle_after", 32'(idle), 32'd1);
        check("fetch_rdata", 32'(rdata), 32'(exp_rdata));
        check("fetch_cfg_byte", 32'(cfg_byte), 32'(exp_rdata));
        check("fetch_cfg_valid", 32'(cfg_valid), 32'(mode == c_m_normal));
        repeat (20) @(posedge CLK);
        #1;
        check("fetch_no_retry", fcs_falls - f0, 1);
        check("fetch_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        bit found;
        do_fetch(c_m_normal, 1'b1);
        run_txn(1'b1, 7'h46, 8'h01, c_m_normal, 0, 1'b1);
        run_txn(1'b0, 7'h46, 8'h00, c_m_normal, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            run_txn(1'($urandom), 7'($urandom), 8'($urandom), c_m_normal,
                    int'($urandom_range(0, 3)), 1'($urandom));
        end
        check("cfg_sticky", 32'({cfg_valid, cfg_byte}), 32'({1'b1, 8'h5A}));
        run_txn(1'b0, 7'($urandom), 8'h00, c_m_stuck, 0, 1'b0);
        run_txn(1'b1, 7'h11, 8'hC3, c_m_normal, 1, 1'b0);
        run_txn(1'b0, 7'h11, 8'h00, c_m_absent, 0, 1'b0);
        run_txn(1'b0, 7'h11, 8'h00, c_m_normal, 2, 1'b0);
        do_fetch(c_m_absent, 1'b0);

        // Abort a write mid-strobe with an asynchronous reset.
        @(negedge CLK);
        resp_mode = c_m_normal; resp_delay = 6;
        req = 1'b1; req_write = 1'b1; req_addr = 7'h20; req_wdata = 8'h33;
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge CLK);
            #1;
            req = 1'b0;
            if (!FCS_n) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_strobe_seen", 32'(found), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("midrst_outputs", 32'({FCS_n, DOE, done, err, busy}), 32'(5'b10000));
        do_fetch(c_m_normal, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
